// File: rtl/gerador_tick_frac_if.sv
// Control/status bundle of the fractional baud-tick generator.
interface gerador_tick_frac_if #(
  parameter int unsigned ACC_W = 32
);
  logic             enable;
  logic             baud_wr;
  logic [31:0]      baud_in;
  logic             busy;
  logic             cfg_err;
  logic [ACC_W-1:0] incr;
  logic             tick;
  logic             bit_tick;

  modport master (
    output enable, baud_wr, baud_in,
    input  busy, cfg_err, incr, tick, bit_tick
  );

  modport slave (
    input  enable, baud_wr, baud_in,
    output busy, cfg_err, incr, tick, bit_tick
  );
endinterface

// File: rtl/gerador_tick_frac.sv
// Phase-accumulator oversample tick generator; the phase increment for a new
// baud rate is computed by a serial restoring divider (one quotient bit/cycle).
module gerador_tick_frac #(
  parameter int unsigned CLK_HZ       = 50000000,
  parameter int unsigned OVS          = 16,
  parameter int unsigned ACC_W        = 32,
  parameter int unsigned DEFAULT_BAUD = 115200
) (
  input logic               clock50M,
  input logic               reset,
  gerador_tick_frac_if.slave bus
);

  localparam int unsigned CW  = $clog2(ACC_W + 1);
  localparam int unsigned OCW = $clog2(OVS);
  localparam logic [39:0] CLK40  = 40'(CLK_HZ);
  localparam logic [39:0] HALF40 = 40'(CLK_HZ / 2);

  function automatic logic [ACC_W-1:0] calc_inc(input logic [39:0] baud);
    logic [127:0] num;
    num = (128'(baud) * 128'(OVS)) << ACC_W;
    return ACC_W'(num / 128'(CLK_HZ));
  endfunction

  localparam logic [ACC_W-1:0] INC_RST = calc_inc(40'(DEFAULT_BAUD));

  typedef enum logic [1:0] {IDLE, DIV, LOAD} state_t;

  state_t           state;
  logic [39:0]      rem;
  logic [ACC_W-1:0] quo;
  logic [CW-1:0]    iter;
  logic [ACC_W-1:0] acc;
  logic [OCW-1:0]   ovs_cnt;

  logic [39:0]      scaled;
  logic             wr_bad;
  logic [40:0]      dbl;
  logic             ge;
  logic [39:0]      rem_next;
  logic [ACC_W:0]   sum;

  always_comb begin
    scaled   = 40'(bus.baud_in) * 40'(OVS);
    wr_bad   = (bus.baud_in == '0) || (scaled > HALF40);
    dbl      = {rem, 1'b0};
    ge       = dbl >= {1'b0, CLK40};
    // the true difference is below CLK_HZ, so 40-bit modular subtraction is exact
    rem_next = ge ? (dbl[39:0] - CLK40) : dbl[39:0];
    sum      = {1'b0, acc} + {1'b0, bus.incr};
  end

  always_ff @(posedge clock50M or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      rem          <= '0;
      quo          <= '0;
      iter         <= '0;
      acc          <= '0;
      ovs_cnt      <= '0;
      bus.busy     <= 1'b0;
      bus.cfg_err  <= 1'b0;
      bus.incr     <= INC_RST;
      bus.tick     <= 1'b0;
      bus.bit_tick <= 1'b0;
    end else begin
      bus.tick     <= 1'b0;
      bus.bit_tick <= 1'b0;

      // LOAD restarts the phase with the new increment and suppresses any carry
      if (state == LOAD) begin
        acc     <= '0;
        ovs_cnt <= '0;
      end else if (bus.enable) begin
        acc      <= sum[ACC_W-1:0];
        bus.tick <= sum[ACC_W];
        if (sum[ACC_W]) begin
          if (ovs_cnt == OCW'(OVS - 1)) begin
            ovs_cnt      <= '0;
            bus.bit_tick <= 1'b1;
          end else begin
            ovs_cnt <= ovs_cnt + 1'b1;
          end
        end
      end

      case (state)
        IDLE: begin
          if (bus.baud_wr) begin
            if (wr_bad) begin
              bus.cfg_err <= 1'b1;
            end else begin
              bus.cfg_err <= 1'b0;
              rem         <= scaled;
              quo         <= '0;
              iter        <= CW'(ACC_W);
              bus.busy    <= 1'b1;
              state       <= DIV;
            end
          end
        end
        DIV: begin
          rem  <= rem_next;
          quo  <= {quo[ACC_W-2:0], ge};
          iter <= iter - 1'b1;
          if (iter == CW'(1)) state <= LOAD;
        end
        LOAD: begin
          bus.incr <= quo;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/gerador_tick_frac.md
GERADOR_TICK_FRAC -- requirements
Module: gerador_tick_frac

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 50000000, meaning the clock50M frequency in Hz.
REQ-002 The block SHALL have parameter OVS, default 16, meaning ticks per bit; legal range is 2..256.
REQ-003 The block SHALL have parameter ACC_W, default 32, meaning phase-accumulator width in bits; legal range is 24..40.
REQ-004 The block SHALL have parameter DEFAULT_BAUD, default 115200, meaning the baud rate in force after reset.
REQ-005 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-006 Port clock50M  input  1  sole clock; all state updates on the rising edge.
REQ-007 Port reset  input  1  asynchronous, active-high reset.
REQ-008 Port enable  input  1  1 = accumulator advances; 0 = accumulator frozen, no ticks.
REQ-009 Port baud_wr  input  1  single-cycle request to load baud_in.
REQ-010 Port baud_in  input  32  requested baud rate in Hz, unsigned.
REQ-011 Port busy  output  1  divider running; baud_wr is ignored while busy=1.
REQ-012 Port cfg_err  output  1  sticky flag: the last baud_wr was rejected.
REQ-013 Port incr  output  ACC_W  phase increment currently in force.
REQ-014 Port tick  output  1  registered one-cycle oversample tick.
REQ-015 Port bit_tick  output  1  registered one-cycle pulse on every OVS-th tick.

Function
REQ-016 Phase increment SHALL be INC = floor(baud*OVS*2^ACC_W / CLK_HZ), computed exactly with no rounding up.
REQ-017 The reset value of incr SHALL be INC for DEFAULT_BAUD, computed at elaboration.
REQ-018 The control FSM SHALL have three states: IDLE, DIV and LOAD.
REQ-019 In IDLE, baud_wr=1 with baud_in=0, or with baud_in*OVS > CLK_HZ/2 (evaluated 40-bit unsigned), SHALL set cfg_err=1, leave incr unchanged and stay in IDLE.
REQ-020 In IDLE, baud_wr=1 with a legal baud_in SHALL clear cfg_err, latch R=baud_in*OVS, clear Q, load an iteration counter with ACC_W and go to DIV.
REQ-021 In DIV, each cycle SHALL perform one restoring step: R<=2R; if 2R>=CLK_HZ then R<=2R-CLK_HZ and shift 1 into Q, else shift 0 into Q; after the ACC_W-th step the FSM SHALL go to LOAD.
REQ-022 In LOAD, the block SHALL set incr<=Q, clear the accumulator and the OVS counter, and return to IDLE.
REQ-023 busy SHALL be 1 exactly in DIV and LOAD: ACC_W+1 cycles, starting the cycle after baud_wr is accepted.
REQ-024 baud_wr while busy=1 SHALL be ignored, with no effect on cfg_err.
REQ-025 During DIV, ticks SHALL continue using the old incr.
REQ-026 Each cycle with enable=1, the block SHALL compute {carry,acc}<=acc+incr (ACC_W+1 bits, acc wraps) and register tick<=carry.
REQ-027 With enable=0, acc and the OVS counter SHALL hold, and tick=bit_tick=0 on the next cycle.
REQ-028 The OVS counter SHALL count ticks 0..OVS-1, wrap to 0, and assert bit_tick in the same cycle as the tick that wraps it.
REQ-029 The LOAD cycle SHALL produce no tick, even when carry would occur.

Reset
REQ-030 Reset SHALL force: state=IDLE, acc=0, OVS counter=0, R=Q=0, busy=0, cfg_err=0, tick=0, bit_tick=0, incr=INC(DEFAULT_BAUD).
REQ-031 Reset asserted during DIV SHALL abort the division; the partial Q SHALL never reach incr.

Verification (CLK_HZ=50000000, OVS=16, ACC_W=32)
REQ-032 Release reset, enable=1 for 1000000 cycles -> incr=158329674, tick count=36863, bit_tick count=2303, tick spacing 27 or 28 cycles only.
REQ-033 baud_wr with baud_in=9600 -> busy high for 33 cycles, then incr=13194139, cfg_err=0, first tick no earlier than 326 cycles after LOAD.
REQ-034 baud_wr with baud_in=0, then a separate baud_wr with 2000000 -> cfg_err=1 after each, incr stays 158329674, busy never asserted.
REQ-035 baud_wr at 9600, second baud_wr at 57600 issued 5 cycles later, reset pulsed at DIV step 20 of a third request -> second request ignored; after reset incr=158329674 and busy=0.
REQ-036 enable=0 for 100 cycles mid-run -> no tick or bit_tick; on re-enable, acc resumes from its held value (next-tick timing matches an uninterrupted reference model shifted by 100 cycles).
